tx_link_sequencer: RTL
======================

# tx_link_sequencer

Symbol-level controller that sequences the 8b/10b serial transmitter. It drives the transmitter's byte input, K flag, enable and electrical-idle controls. After link enable it performs a fixed training burst, then grants a single byte-wide requester access to the link. It fills unused slots with logical idle and, optionally, inserts periodic SKP ordered sets. It sits between the data source and the transmitter, one per lane, in the `clk` (`clkTx`) domain.

## Interface
- `SYM_CYCLES`, default 10: clk cycles per 10-bit symbol; minimum 2.
- `TS_COUNT`, default 16: training ordered sets sent per link-up; minimum 1.
- `SKP_INTERVAL`, default 128: LINK_UP symbols between SKP ordered sets; minimum 8.
- `clk` in 1: single clock. Same clock as the transmitter's `clk`.
- `rst` in 1: synchronous, active-low reset.
- `link_en` in 1: request link active; level-sensitive.
- `req_valid` in 1: requester has a symbol.
- `req_data` in 8: requester byte.
- `req_k` in 1: requester byte is a control (K) symbol.
- `req_ready` out 1: symbol accepted this cycle when `req_valid` is also high.
- `dataIn8` out 8: byte to transmitter.
- `K` out 1: K flag to transmitter.
- `enb` out 1: transmitter enable; high in every state except ELEC_IDLE.
- `TxElecIdle` out 1: electrical idle to transmitter.
- `sym_load` out 1: one-cycle pulse when a new symbol appears on `dataIn8`/`K`.
- `link_up` out 1: high while in LINK_UP or SKP.

## Operation
- Symbol counter `sym_cnt` runs 0..SYM_CYCLES-1 continuously from reset.
- A boundary is the cycle with `sym_cnt == SYM_CYCLES-1`. All state and symbol changes take effect on the edge ending a boundary cycle.
- States:
  - ELEC_IDLE: `TxElecIdle`=1, `enb`=0, `dataIn8`=8'h00, `K`=0.
  - TRAIN: sends TS_COUNT training sets. Each set is BC(K=1), 4A, 4A, 4A (K=0).
  - LINK_UP: sends requester symbols or logical idle 8'h00 (K=0).
  - SKP: sends one SKP set: BC(K=1), 1C, 1C, 1C (all K=1).
- Intra-set symbol index is 2 bits; the training-set counter is wide enough to hold TS_COUNT.
- Transitions, evaluated at boundaries:
  - ELEC_IDLE→TRAIN when `link_en`=1.
  - TRAIN→LINK_UP after the last symbol of set TS_COUNT.
  - LINK_UP→SKP when `skp_due`=1.
  - SKP→LINK_UP after its 4th symbol.
  - LINK_UP→ELEC_IDLE when `link_en`=0.
- `link_en`=0 during TRAIN or SKP is ignored until the current ordered set completes. At that point the next state is ELEC_IDLE. A new link-up always restarts a full training burst.
- `req_ready` is combinational: (state==LINK_UP) && boundary && `link_en` && !`skp_due`.
  - Transfer on `req_valid`&&`req_ready`: next symbol = {`req_k`,`req_data`}.
  - Otherwise the next LINK_UP symbol is logical idle.
- `skp_due` priority: `skp_due` beats a pending request. `link_en`=0 beats `skp_due`, so the link drops without SKP.
- SKP counter counts every LINK_UP symbol, including idle, saturating at SKP_INTERVAL. `skp_due` = (count == SKP_INTERVAL). The counter clears when an SKP set starts and on entering LINK_UP from TRAIN.
- Reset (`rst`=0 at an edge), in any state including mid-set:
  - state ELEC_IDLE, `sym_cnt`=0, all counters 0.
  - `dataIn8`=8'h00, `K`=0, `enb`=0, `TxElecIdle`=1.
  - `req_ready`=0, `sym_load`=0, `link_up`=0.

## Timing
- `dataIn8`, `K`, `enb`, `TxElecIdle`, `link_up` are registered and change only on the edge after a boundary. `sym_load` pulses in the cycle immediately after that edge.
- `link_en` sampled high at a boundary → first BC(K=1) and `TxElecIdle`=0 visible the next cycle. Worst-case latency from `link_en` rise is SYM_CYCLES cycles.
- Training duration: exactly 4·TS_COUNT symbols = 4·TS_COUNT·SYM_CYCLES cycles. `link_up` rises with the first LINK_UP symbol.
- Accepted request → byte on `dataIn8` the next cycle. It holds for SYM_CYCLES cycles.
- Exit: `TxElecIdle`=1 and `enb`=0 on the edge after the boundary where the exit is taken.

## Configuration
- `TX_SKP_EN` defined: SKP counter, `skp_due`, and SKP state are present as described.
- `TX_SKP_EN` undefined:
  - No SKP hardware; `skp_due` tied to 0.
  - LINK_UP never leaves except on `link_en`=0.
  - SKP_INTERVAL is unused.

## Test plan
Bench parameters: SYM_CYCLES=10, TS_COUNT=2, SKP_INTERVAL=8.
- Reset: `rst`=0 for 3 cycles then 1, `link_en`=0 → `TxElecIdle`=1, `enb`=0, `dataIn8`=00, `req_ready` never high.
- Training: raise `link_en` → sequence BC/K, 4A, 4A, 4A, BC/K, 4A, 4A, 4A, each held 10 cycles. `link_up` rises on the 9th symbol, which is idle 00.
- Data: `req_valid`=1 with A5,K=0 then BC,K=1 → two consecutive symbols A5/0, BC/1. `req_ready` pulses exactly once per accepted symbol.
- SKP (with `TX_SKP_EN`): idle link → after 8 LINK_UP symbols, BC/K, 1C/K, 1C/K, 1C/K appear. `req_ready`=0 throughout. Without the macro, idle 00 continues.
- Drop during TRAIN: `link_en`=0 on the 2nd symbol of the first set → set completes (4A, 4A), then `TxElecIdle`=1. Re-raise → full 8-symbol training repeats.
- Reset mid-SKP: `rst`=0 on the 2nd SKP symbol → next cycle all outputs at reset values, state ELEC_IDLE.

Source files
------------

// File: rtl/tx_link_sequencer.sv
// tx_link_sequencer
//
// Symbol-level controller for one lane of the 8b/10b serial transmitter.
// After link enable it sends a fixed burst of training ordered sets, then
// hands the link to a single byte-wide requester. Slots with no request are
// filled with logical idle (8'h00). Every symbol is held for SYM_CYCLES
// clocks, and all state and symbol changes happen on the edge that ends the
// last cycle of a symbol (the "boundary" cycle).
//
// Optional feature: define TX_SKP_EN to insert one SKP ordered set after
// every SKP_INTERVAL LINK_UP symbols. Without TX_SKP_EN there is no SKP
// counter, skp_due is tied low and SKP_INTERVAL has no effect.
//
// Parameters:
//   SYM_CYCLES   clk cycles per 10-bit symbol (>= 2)
//   TS_COUNT     training ordered sets per link-up (>= 1)
//   SKP_INTERVAL LINK_UP symbols between SKP ordered sets (>= 8)
//
// Ports:
//   clk        single clock, shared with the transmitter
//   rst        synchronous, active-low reset
//   link_en    level request for an active link
//   req_valid  requester has a symbol
//   req_data   requester byte
//   req_k      requester byte is a K symbol
//   req_ready  symbol accepted this cycle when req_valid is also high
//   dataIn8    byte to the transmitter
//   K          K flag to the transmitter
//   enb        transmitter enable, low only in electrical idle
//   TxElecIdle electrical idle control to the transmitter
//   sym_load   one-cycle pulse when a new symbol appears on dataIn8/K
//   link_up    high while the link carries requester traffic or SKP sets

module tx_link_sequencer #(
   parameter int SYM_CYCLES   = 10,
   parameter int TS_COUNT     = 16,
   parameter int SKP_INTERVAL = 128
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       link_en,
   input  logic       req_valid,
   input  logic [7:0] req_data,
   input  logic       req_k,
   output logic       req_ready,
   output logic [7:0] dataIn8,
   output logic       K,
   output logic       enb,
   output logic       TxElecIdle,
   output logic       sym_load,
   output logic       link_up
);

   localparam int SymW = $clog2(SYM_CYCLES);
   localparam int TsW  = $clog2(TS_COUNT + 1);

   // Symbols as {K, byte}.
   localparam logic [8:0] SymTsHead  = 9'h1BC;
   localparam logic [8:0] SymTsBody  = 9'h04A;
   localparam logic [8:0] SymSkpHead = 9'h1BC;
   localparam logic [8:0] SymSkpBody = 9'h11C;
   localparam logic [8:0] SymIdle    = 9'h000;

   // An out-of-range parameter set keeps the lane parked in electrical idle
   // rather than sending malformed ordered sets.
   localparam bit ParamsOk = (SYM_CYCLES >= 2) && (TS_COUNT >= 1) && (SKP_INTERVAL >= 8);

   typedef enum logic [1:0] {
      ELEC_IDLE,
      TRAIN,
      LINK_UP,
      SKP
   } state_t;

   state_t          state_q, state_d;
   logic [SymW-1:0] symCnt_q, symCnt_d;
   logic [1:0]      idx_q, idx_d;
   logic [TsW-1:0]  tsCnt_q, tsCnt_d;
   logic [7:0]      data_q, data_d;
   logic            k_q, k_d;
   logic            enb_q, enb_d;
   logic            elecIdle_q, elecIdle_d;
   logic            linkUp_q, linkUp_d;
   logic            symLoad_q, symLoad_d;

   logic            boundary;
   logic            linkReq;
   logic            setDone;
   logic            skpDue;
   logic            goIdle;
   logic            loadNew;
   logic [8:0]      symNext;

   assign boundary = (symCnt_q == SymW'(SYM_CYCLES - 1));
   assign linkReq  = link_en && ParamsOk;
   assign setDone  = (idx_q == 2'd3);

`ifdef TX_SKP_EN
   localparam int SkpW = $clog2(SKP_INTERVAL + 1);

   logic [SkpW-1:0] skpCnt_q, skpCnt_d;

   assign skpDue = (skpCnt_q == SkpW'(SKP_INTERVAL));
`else
   assign skpDue = 1'b0;
`endif

   // A request is only offered on a LINK_UP boundary that is neither a
   // link drop nor an SKP insertion, so the requester never loses a byte.
   assign req_ready = (state_q == LINK_UP) && boundary && linkReq && !skpDue;

   // Next-state logic. idx_q is the position of the symbol currently on the
   // wire inside its ordered set; an ordered set may only be abandoned once
   // its fourth symbol has been sent, which is why link drops in TRAIN and
   // SKP wait for setDone. The SKP counter advances in the cycle after each
   // LINK_UP symbol is loaded, so at a boundary it already includes the
   // symbol that is ending.
   always_comb begin
      state_d   = state_q;
      symCnt_d  = boundary ? '0 : symCnt_q + SymW'(1);
      idx_d     = idx_q;
      tsCnt_d   = tsCnt_q;
      symLoad_d = 1'b0;
      goIdle    = 1'b0;
      loadNew   = 1'b0;
      symNext   = SymIdle;
`ifdef TX_SKP_EN
      skpCnt_d  = (state_q == LINK_UP && symLoad_q && !skpDue) ? skpCnt_q + SkpW'(1) : skpCnt_q;
`endif

      if (boundary) begin
         case (state_q)
            ELEC_IDLE: begin
               if (linkReq) begin
                  state_d = TRAIN;
                  idx_d   = 2'd0;
                  tsCnt_d = '0;
                  symNext = SymTsHead;
                  loadNew = 1'b1;
               end
            end
            TRAIN: begin
               if (!setDone) begin
                  idx_d   = idx_q + 2'd1;
                  symNext = SymTsBody;
                  loadNew = 1'b1;
               end else if (!linkReq) begin
                  goIdle = 1'b1;
               end else if (tsCnt_q == TsW'(TS_COUNT - 1)) begin
                  state_d  = LINK_UP;
                  symNext  = SymIdle;
                  loadNew  = 1'b1;
`ifdef TX_SKP_EN
                  skpCnt_d = '0;
`endif
               end else begin
                  tsCnt_d = tsCnt_q + TsW'(1);
                  idx_d   = 2'd0;
                  symNext = SymTsHead;
                  loadNew = 1'b1;
               end
            end
            LINK_UP: begin
               if (!linkReq) begin
                  goIdle = 1'b1;
`ifdef TX_SKP_EN
               end else if (skpDue) begin
                  state_d  = SKP;
                  idx_d    = 2'd0;
                  skpCnt_d = '0;
                  symNext  = SymSkpHead;
                  loadNew  = 1'b1;
`endif
               end else if (req_valid) begin
                  symNext = {req_k, req_data};
                  loadNew = 1'b1;
               end else begin
                  symNext = SymIdle;
                  loadNew = 1'b1;
               end
            end
`ifdef TX_SKP_EN
            SKP: begin
               if (!setDone) begin
                  idx_d   = idx_q + 2'd1;
                  symNext = SymSkpBody;
                  loadNew = 1'b1;
               end else if (!linkReq) begin
                  goIdle = 1'b1;
               end else begin
                  state_d = LINK_UP;
                  symNext = SymIdle;
                  loadNew = 1'b1;
               end
            end
`endif
            default: begin
               goIdle = 1'b1;
            end
         endcase
      end

      if (goIdle) begin
         state_d = ELEC_IDLE;
      end

      data_d = data_q;
      k_d    = k_q;
      if (goIdle) begin
         data_d = 8'h00;
         k_d    = 1'b0;
      end else if (loadNew) begin
         data_d    = symNext[7:0];
         k_d       = symNext[8];
         symLoad_d = 1'b1;
      end

      // The line controls follow the state being entered; state_d only
      // moves at boundaries, so these registers only move on boundary edges.
      enb_d      = (state_d != ELEC_IDLE);
      elecIdle_d = (state_d == ELEC_IDLE);
      linkUp_d   = (state_d == LINK_UP) || (state_d == SKP);
   end

   // All sequencer state and every transmitter-facing output in one
   // registered block, cleared together by the synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ELEC_IDLE;
         symCnt_q   <= '0;
         idx_q      <= 2'd0;
         tsCnt_q    <= '0;
         data_q     <= 8'h00;
         k_q        <= 1'b0;
         enb_q      <= 1'b0;
         elecIdle_q <= 1'b1;
         linkUp_q   <= 1'b0;
         symLoad_q  <= 1'b0;
`ifdef TX_SKP_EN
         skpCnt_q   <= '0;
`endif
      end else begin
         state_q    <= state_d;
         symCnt_q   <= symCnt_d;
         idx_q      <= idx_d;
         tsCnt_q    <= tsCnt_d;
         data_q     <= data_d;
         k_q        <= k_d;
         enb_q      <= enb_d;
         elecIdle_q <= elecIdle_d;
         linkUp_q   <= linkUp_d;
         symLoad_q  <= symLoad_d;
`ifdef TX_SKP_EN
         skpCnt_q   <= skpCnt_d;
`endif
      end
   end

   assign dataIn8    = data_q;
   assign K          = k_q;
   assign enb        = enb_q;
   assign TxElecIdle = elecIdle_q;
   assign sym_load   = symLoad_q;
   assign link_up    = linkUp_q;

endmodule
